register_file: RTL and testbench



---
 rtl/register_file.sv | 45 ++++
 tb/tb_register_file.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Two-read, one-write register file for the 16-bit datapath.
// Reads are combinational; a single write port updates on the rising edge of Clock.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic [ADDR_WIDTH-1:0] RS,
    input  logic [ADDR_WIDTH-1:0] RT,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  Clock,
    output logic [DATA_WIDTH-1:0] ReadRS,
    output logic [DATA_WIDTH-1:0] ReadRT,
    input  logic                  Reset
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // NOTE: defaulting regs_d to the current state first means no path leaves it unassigned, so no latch.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite) begin
            regs_d[RD] = WriteData;
        end
    end

    // NOTE: the array is only a handful of flops, so it is cleared outright rather than left as an unreset RAM.
    // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // No bypass: a read of RD sees the old value until the write edge.
    assign ReadRS = regs_q[RS];
    assign ReadRT = regs_q[RT];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference array predicts reads,
// expected values go through a scoreboard queue and are compared after the read settles.
module tb_register_file;

    logic [1:0]  RS;
    logic [1:0]  RT;
    logic [1:0]  RD;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic        Clock;
    logic        Reset;
    logic [15:0] ReadRS;
    logic [15:0] ReadRT;

    logic [15:0] model [4];
    logic [15:0] exp_q [$];
    int          total;
    int          bad;

    register_file dut (
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Clock     (Clock),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT),
        .Reset     (Reset)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one edge of write/reset, update the reference, then release the controls.
    task automatic do_edge(input logic [1:0] rd, input logic [15:0] wd,
                           input logic we, input logic rst);
        @(negedge Clock);
        RD        = rd;
        WriteData = wd;
        RegWrite  = we;
        Reset     = rst;
        @(posedge Clock);
        if (rst) begin
            for (int i = 0; i < 4; i++) model[i] = '0;
        end else if (we) begin
            model[rd] = wd;
        end
        #1;
        RegWrite = 1'b0;
        Reset    = 1'b0;
    endtask

    task automatic read_pair(input logic [1:0] rs, input logic [1:0] rt, input string tag);
        @(negedge Clock);
        RS = rs;
        RT = rt;
        exp_q.push_back(model[rs]);
        exp_q.push_back(model[rt]);
        #1;
        check($sformatf("%s_rs%0d", tag, rs), ReadRS, exp_q.pop_front());
        check($sformatf("%s_rt%0d", tag, rt), ReadRT, exp_q.pop_front());
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                read_pair(a[1:0], b[1:0], tag);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        RS        = '0;
        RT        = '0;
        RD        = '0;
        WriteData = '0;
        RegWrite  = 1'b0;
        Reset     = 1'b0;

        do_edge(2'd0, 16'h0000, 1'b0, 1'b1);
        sweep("reset_init");

        do_edge(2'd2, 16'd5, 1'b1, 1'b0);
        do_edge(2'd3, 16'd7, 1'b1, 1'b0);
        read_pair(2'd2, 2'd3, "basic");
        check("basic_lit_rs", ReadRS, 16'd5);
        check("basic_lit_rt", ReadRT, 16'd7);

        do_edge(2'd2, 16'hFFFF, 1'b0, 1'b0);
        read_pair(2'd2, 2'd2, "wr_disable");
        check("wr_disable_lit", ReadRS, 16'd5);

        do_edge(2'd0, 16'h1111, 1'b1, 1'b0);
        do_edge(2'd1, 16'h2222, 1'b1, 1'b0);
        do_edge(2'd2, 16'h8000, 1'b1, 1'b0);
        do_edge(2'd3, 16'hFFFF, 1'b1, 1'b0);
        sweep("full");
        read_pair(2'd3, 2'd3, "same");
        check("same_lit", ReadRT, 16'hFFFF);

        // Read-during-write on register 1, written with 16'h1111 first.
        do_edge(2'd1, 16'h1111, 1'b1, 1'b0);
        @(negedge Clock);
        RS        = 2'd1;
        RT        = 2'd1;
        RD        = 2'd1;
        WriteData = 16'hABCD;
        RegWrite  = 1'b1;
        exp_q.push_back(16'h1111);
        #1;
        check("rdw_before", ReadRS, exp_q.pop_front());
        @(posedge Clock);
        model[1] = 16'hABCD;
        #1;
        RegWrite = 1'b0;
        exp_q.push_back(16'hABCD);
        check("rdw_after", ReadRS, exp_q.pop_front());

        do_edge(2'd0, 16'h1234, 1'b1, 1'b1);
        read_pair(2'd0, 2'd1, "rst_prio");
        check("rst_prio_lit", ReadRS, 16'h0000);

        for (int n = 0; n < 24; n++) begin
            do_edge(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 1'b0);
            read_pair(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand");
        end

        do_edge(2'd3, 16'h5A5A, 1'b1, 1'b0);
        do_edge(2'd0, 16'h0000, 1'b0, 1'b1);
        sweep("reset_after");

        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
